// File: rtl/gen_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gen_frame_sequencer
// Brief    : Frame sequencer in front of generator_v3: forwards one frame,
//            counts outputs, then pulses a soft clear before the next frame.
//            Optional DRAIN watchdog enabled by macro GEN_SEQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module gen_frame_sequencer #(
  parameter int DATA_WIDTH     = 16,
  parameter int PIXELS_IN      = 1024,
  parameter int PIXELS_OUT     = 1024,
  parameter int FLUSH_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [DATA_WIDTH-1:0]           s_data,
  output logic                            gen_valid_in,
  output logic [DATA_WIDTH-1:0]           gen_data_in,
  input  logic                            gen_valid_out,
  output logic                            gen_clear,
  output logic                            frame_start,
  output logic                            frame_done,
  output logic                            busy,
  output logic [$clog2(PIXELS_IN+1)-1:0]  in_cnt,
  output logic [$clog2(PIXELS_OUT+1)-1:0] out_cnt,
  output logic                            timeout_err
);

  localparam int c_in_w  = $clog2(PIXELS_IN + 1);
  localparam int c_out_w = $clog2(PIXELS_OUT + 1);
  localparam int c_fl_w  = $clog2(FLUSH_CYCLES + 1);

  localparam logic [c_in_w-1:0]  c_in_last = c_in_w'(PIXELS_IN - 1);
  localparam logic [c_out_w-1:0] c_out_max = c_out_w'(PIXELS_OUT);
  localparam logic [c_fl_w-1:0]  c_fl_last = c_fl_w'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t                  state_q;
  logic [c_in_w-1:0]       in_cnt_q;
  logic [c_out_w-1:0]      out_cnt_q;
  logic [c_out_w-1:0]      out_cnt_d;
  logic [c_fl_w-1:0]       fl_cnt_q;
  logic                    gen_valid_in_q;
  logic [DATA_WIDTH-1:0]   gen_data_in_q;
  logic                    gen_clear_q;
  logic                    frame_start_q;
  logic                    frame_done_q;

  logic                    w_accept;
  logic                    w_out_hit;
  logic                    w_timeout;

  assign s_ready   = !rst && (state_q == S_IDLE || state_q == S_FEED);
  assign w_accept  = s_valid && s_ready;

  // Outputs seen in IDLE/FLUSH are strays from a previous frame and are ignored.
  assign w_out_hit = gen_valid_out && (state_q == S_FEED || state_q == S_DRAIN) &&
                     (out_cnt_q != c_out_max);
  assign out_cnt_d = w_out_hit ? out_cnt_q + c_out_w'(1) : out_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      in_cnt_q       <= '0;
      out_cnt_q      <= '0;
      fl_cnt_q       <= '0;
      gen_valid_in_q <= 1'b0;
      gen_data_in_q  <= '0;
      gen_clear_q    <= 1'b0;
      frame_start_q  <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      gen_valid_in_q <= w_accept;
      if (w_accept) begin
        gen_data_in_q <= s_data;
      end
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      out_cnt_q     <= out_cnt_d;

      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            frame_start_q <= 1'b1;
            in_cnt_q      <= c_in_w'(1);
            state_q       <= (PIXELS_IN == 1) ? S_DRAIN : S_FEED;
          end
        end
        S_FEED: begin
          if (w_accept) begin
            in_cnt_q <= in_cnt_q + c_in_w'(1);
            if (in_cnt_q == c_in_last) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Registered count: FLUSH follows one cycle after the last output.
          if (out_cnt_q == c_out_max || w_timeout) begin
            state_q      <= S_FLUSH;
            frame_done_q <= 1'b1;
            gen_clear_q  <= 1'b1;
            fl_cnt_q     <= c_fl_last;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
          end
        end
        S_FLUSH: begin
          if (fl_cnt_q == '0) begin
            state_q     <= S_IDLE;
            gen_clear_q <= 1'b0;
          end else begin
            fl_cnt_q <= fl_cnt_q - c_fl_w'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef GEN_SEQ_TIMEOUT_EN
  localparam int                c_to_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYCLES - 1);

  logic [c_to_w-1:0] to_cnt_q;
  logic              timeout_err_q;

  assign w_timeout = (state_q == S_DRAIN) && !gen_valid_out && (to_cnt_q == c_to_last);

  always_ff @(posedge clk) begin
    if (rst || state_q != S_DRAIN || gen_valid_out) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + c_to_w'(1);
    end

    if (rst) begin
      timeout_err_q <= 1'b0;
    end else if (w_timeout) begin
      timeout_err_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;

  // Keeps the watchdog length referenced when the watchdog is compiled out.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  assign gen_valid_in = gen_valid_in_q;
  assign gen_data_in  = gen_data_in_q;
  assign gen_clear    = gen_clear_q;
  assign frame_start  = frame_start_q;
  assign frame_done   = frame_done_q;
  assign busy         = (state_q != S_IDLE);
  assign in_cnt       = in_cnt_q;
  assign out_cnt      = out_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_gen_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gen_frame_sequencer
// Brief    : Self-checking bench for gen_frame_sequencer (frame-level model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gen_frame_sequencer;

  localparam int DW   = 16;
  localparam int PIN  = 1024;
  localparam int POUT = 1024;
  localparam int FL   = 4;
  localparam int TMO  = 4096;
  localparam int IN_W  = $clog2(PIN + 1);
  localparam int OUT_W = $clog2(POUT + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [DW-1:0]   s_data = '0;
  logic            gen_valid_in;
  logic [DW-1:0]   gen_data_in;
  logic            gen_valid_out = 1'b0;
  logic            gen_clear;
  logic            frame_start;
  logic            frame_done;
  logic            busy;
  logic [IN_W-1:0] in_cnt;
  logic [OUT_W-1:0] out_cnt;
  logic            timeout_err;

  gen_frame_sequencer #(
    .DATA_WIDTH(DW), .PIXELS_IN(PIN), .PIXELS_OUT(POUT),
    .FLUSH_CYCLES(FL), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .gen_valid_in(gen_valid_in), .gen_data_in(gen_data_in), .gen_valid_out(gen_valid_out),
    .gen_clear(gen_clear), .frame_start(frame_start), .frame_done(frame_done), .busy(busy),
    .in_cnt(in_cnt), .out_cnt(out_cnt), .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level model: pixels accepted, outputs counted, edge of FLUSH entry.
  int            m_e = 0, m_acc = 0, m_outs = 0, m_fs = -1, m_last = 0;
  bit            m_gvi = 0, m_fstart = 0, m_done = 0, m_terr = 0;
  logic [DW-1:0] m_gdata = '0;

  // Generator stand-in: each accepted pixel returns one output g_lat edges later.
  int gq[$];
  int g_pushed = 0, g_popped = 0, g_max = POUT, g_lat = 3;
  int last_out_edge = -1, terr_edge = -1;

  int st_gvi = 0, st_start = 0, st_done = 0, st_clear = 0, peak_in = 0;

  typedef struct {
    bit r;
    bit sv;
    bit gvo;
    bit rdy;
    bit bsy;
    int ocnt;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (edge %0d)", name, act, exp, m_e);
    end
  endtask

  task automatic clr_stats();
    st_gvi = 0; st_start = 0; st_done = 0; st_clear = 0; peak_in = 0;
  endtask

  task automatic step(input bit r, input bit sv, input logic [DW-1:0] d, input bit gvo,
                      output bit acc);
    bit fl, drain, active, rdy, tmo;
    rst = r; s_valid = sv; s_data = d; gen_valid_out = gvo;
    fl     = (m_fs >= 0);
    drain  = !fl && (m_acc == PIN);
    active = !fl && (m_acc > 0);
    rdy    = !r && !fl && (m_acc < PIN);
    #1;
    chk("s_ready", s_ready, rdy);
    acc = sv && rdy;
    @(posedge clk);
    m_e++;
    tmo = 1'b0;
`ifdef GEN_SEQ_TIMEOUT_EN
    tmo = drain && !gvo && (m_e - m_last == TMO);
`endif
    if (r) begin
      m_acc = 0; m_outs = 0; m_fs = -1; m_gvi = 0; m_fstart = 0; m_done = 0;
      m_terr = 0; m_gdata = '0;
    end else begin
      m_fstart = acc && (m_acc == 0);
      m_gvi    = acc;
      if (acc) m_gdata = d;
      m_done = 0;
      if (fl) begin
        if (m_e == m_fs + FL) m_fs = -1;
      end else if (drain && (m_outs == POUT || tmo)) begin
        m_fs = m_e; m_acc = 0; m_outs = 0; m_done = 1;
        if (tmo) m_terr = 1;
      end else begin
        if (gvo && active && m_outs < POUT) m_outs++;
        if (drain && gvo) m_last = m_e;
        if (acc) begin
          m_acc++;
          if (m_acc == PIN) m_last = m_e;
        end
      end
    end
    #1;
    chk("gen_valid_in", gen_valid_in, m_gvi);
    chk("gen_data_in", gen_data_in, m_gdata);
    chk("gen_clear", gen_clear, m_fs >= 0);
    chk("frame_start", frame_start, m_fstart);
    chk("frame_done", frame_done, m_done);
    chk("busy", busy, (m_acc > 0) || (m_fs >= 0));
    chk("in_cnt", in_cnt, m_acc);
    chk("out_cnt", out_cnt, m_outs);
    chk("timeout_err", timeout_err, m_terr);
    st_gvi   += int'(gen_valid_in);
    st_start += int'(frame_start);
    st_done  += int'(frame_done);
    st_clear += int'(gen_clear);
    if (int'(in_cnt) > peak_in) peak_in = int'(in_cnt);
    if (timeout_err === 1'b1 && terr_edge < 0) terr_edge = m_e;
  endtask

  task automatic run(input int npix, input int density, input bit ramp,
                     input bit wait_idle, input int budget);
    int            sent = 0;
    int            cyc  = 0;
    bit            acc, sv, gvo;
    logic [DW-1:0] d;
    d = ramp ? '0 : DW'($urandom);
    while ((sent < npix || (wait_idle && (m_acc != 0 || m_fs >= 0))) && cyc < budget) begin
      sv = (sent < npix) && ($urandom_range(99) < density);
      while (gq.size() > 0 && gq[0] <= m_e) void'(gq.pop_front());
      gvo = (gq.size() > 0 && gq[0] == m_e + 1);
      if (gvo) begin
        void'(gq.pop_front());
        g_popped++;
        if (g_popped == g_max) last_out_edge = m_e + 1;
      end
      step(1'b0, sv, d, gvo, acc);
      if (m_fstart) begin
        g_pushed = 0;
        g_popped = 0;
      end
      if (acc) begin
        sent++;
        if (g_pushed < g_max) begin
          gq.push_back(m_e + g_lat);
          g_pushed++;
        end
        d = ramp ? DW'(sent) : DW'($urandom);
      end
      cyc++;
    end
    if (cyc >= budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL run_budget: cycles=%0d limit=%0d", cyc, budget);
    end
  endtask

  initial begin
    bit acc;

    // Reset, then five stray generator outputs while idle.
    tbl[0] = '{r:1, sv:1, gvo:1, rdy:0, bsy:0, ocnt:0};
    tbl[1] = '{r:1, sv:0, gvo:0, rdy:0, bsy:0, ocnt:0};
    tbl[2] = '{r:0, sv:0, gvo:1, rdy:1, bsy:0, ocnt:0};
    tbl[3] = '{r:0, sv:0, gvo:1, rdy:1, bsy:0, ocnt:0};
    tbl[4] = '{r:0, sv:0, gvo:1, rdy:1, bsy:0, ocnt:0};
    tbl[5] = '{r:0, sv:0, gvo:1, rdy:1, bsy:0, ocnt:0};
    tbl[6] = '{r:0, sv:0, gvo:1, rdy:1, bsy:0, ocnt:0};
    tbl[7] = '{r:0, sv:0, gvo:0, rdy:1, bsy:0, ocnt:0};
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].r, tbl[i].sv, 16'h5A5A, tbl[i].gvo, acc);
      chk($sformatf("tbl%0d_s_ready", i), s_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("tbl%0d_out_cnt", i), out_cnt, tbl[i].ocnt);
    end

    // Single ramp frame, s_valid held high.
    clr_stats(); g_lat = 3; g_max = POUT;
    run(PIN, 100, 1'b1, 1'b1, 3000);
    chk("single_beats", st_gvi, PIN);
    chk("single_starts", st_start, 1);
    chk("single_dones", st_done, 1);
    chk("single_clear_cycles", st_clear, FL);
    chk("single_idle_in_cnt", in_cnt, 0);
    chk("single_idle_out_cnt", out_cnt, 0);

    // Three back-to-back frames.
    clr_stats(); g_lat = int'($urandom_range(2, 8));
    run(3 * PIN, 100, 1'b0, 1'b1, 8000);
    chk("b2b_beats", st_gvi, 3 * PIN);
    chk("b2b_starts", st_start, 3);
    chk("b2b_dones", st_done, 3);
    chk("b2b_clear_cycles", st_clear, 3 * FL);

    // Upstream bubbles at 50% density.
    clr_stats(); g_lat = 5;
    run(PIN, 50, 1'b0, 1'b1, 6000);
    chk("bubble_beats", st_gvi, PIN);
    chk("bubble_peak_in_cnt", peak_in, PIN);
    chk("bubble_dones", st_done, 1);

    // One-cycle reset after the 500th accept, then a fresh frame.
    clr_stats(); g_lat = 4;
    run(500, 100, 1'b0, 1'b0, 1000);
    step(1'b1, 1'b1, 16'h1234, 1'b0, acc);
    gq.delete();
    chk("rst_gen_valid_in", gen_valid_in, 0);
    chk("rst_gen_data_in", gen_data_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_cnt", in_cnt, 0);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_gen_clear", gen_clear, 0);
    chk("rst_no_done", st_done, 0);
    step(1'b0, 1'b1, 16'h0BEE, 1'b0, acc);
    chk("restart_frame_start", frame_start, 1);
    chk("restart_in_cnt", in_cnt, 1);
    chk("restart_data", gen_data_in, 16'h0BEE);
    g_pushed = 1; g_popped = 0;
    gq.push_back(m_e + g_lat);
    run(PIN - 1, 100, 1'b0, 1'b1, 3000);
    chk("restart_dones", st_done, 1);

`ifdef GEN_SEQ_TIMEOUT_EN
    // Generator stops after 1000 outputs; latency keeps them past DRAIN entry.
    clr_stats(); g_lat = 40; g_max = 1000; last_out_edge = -1; terr_edge = -1;
    run(PIN, 100, 1'b0, 1'b1, 8000);
    chk("tmo_latency", terr_edge - last_out_edge, TMO);
    chk("tmo_dones", st_done, 1);
    g_max = POUT; g_lat = 3;
    run(PIN, 100, 1'b0, 1'b1, 3000);
    chk("tmo_sticky", timeout_err, 1);
    step(1'b1, 1'b0, '0, 1'b0, acc);
    chk("tmo_cleared", timeout_err, 0);
    step(1'b0, 1'b0, '0, 1'b0, acc);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
